en_reg_bank: RTL and testbench
==============================

EN_REG_BANK -- requirements
Module: en_reg_bank

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of storage rows (power of two, 2..16).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the data bits per row.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the asynchronous, active-low reset.
REQ-005 The block SHALL have port wr_valid, input, 1, meaning a write request is present.
REQ-006 The block SHALL have port wr_ready, output, 1, meaning the block accepts a write this cycle.
REQ-007 The block SHALL have port wr_addr, input, log2(DEPTH), meaning the target row.
REQ-008 The block SHALL have port wr_data, input, WIDTH, meaning the write data.
REQ-009 The block SHALL have port clr_req, input, 1, meaning a one-cycle pulse that starts a bulk clear.
REQ-010 The block SHALL have port rd_en, input, 1, meaning a read request.
REQ-011 The block SHALL have port rd_addr, input, log2(DEPTH), meaning the row to read.
REQ-012 The block SHALL have port rd_data, output, WIDTH, meaning registered read data.
REQ-013 The block SHALL have port rd_valid, output, 1, meaning rd_data is valid this cycle.
REQ-014 The block SHALL have port row_en, output, DEPTH, meaning the one-hot per-row load enables for that cycle.
REQ-015 The block SHALL have port busy, output, 1, meaning a bulk clear is in progress.

Function
REQ-016 A write SHALL occur on a cycle where wr_valid and wr_ready are both 1; row wr_addr loads wr_data at that edge.
REQ-017 row_en SHALL be combinational: one-hot on row wr_addr during an accepted write, one-hot on the sweep row during CLEAR, and all zeros otherwise.
REQ-018 Rows whose row_en bit is 0 SHALL hold their value, which is the same hold behaviour as an enable flip-flop.
REQ-019 The FSM SHALL have the states IDLE and CLEAR.
REQ-020 In IDLE, a clr_req pulse SHALL move the FSM to CLEAR and set the sweep counter to 0.
REQ-021 In CLEAR, the block SHALL zero one row per cycle, from row 0 through row DEPTH-1, and then return to IDLE, so CLEAR lasts exactly DEPTH cycles.
REQ-022 wr_ready SHALL be 1 in IDLE and 0 in CLEAR; busy SHALL be its inverse.
REQ-023 If clr_req and an accepted write occur in the same cycle, the write SHALL complete first, and the clear SHALL start on the next cycle.
REQ-024 The block SHALL ignore clr_req while it is in CLEAR, so the sweep does not restart.
REQ-025 A read SHALL have 1-cycle latency: when rd_en=1 at edge N, rd_data holds row rd_addr and rd_valid=1 after edge N.
REQ-026 When rd_en=0, rd_valid SHALL be 0 and rd_data SHALL hold its last value.
REQ-027 If the read and the write hit the same row in the same cycle, rd_data SHALL return the old contents (read-before-write).
REQ-028 Reads SHALL be permitted during CLEAR and SHALL return the current contents of the row, either cleared or not yet cleared.
REQ-029 The sweep counter SHALL be exactly log2(DEPTH) bits wide, and it SHALL detect the end of the sweep when it reaches DEPTH-1, without wrapping into a second pass.

Reset
REQ-030 When rst_n=0, all rows SHALL be 0 asynchronously, with rd_data=0, rd_valid=0, the FSM in IDLE, and the sweep counter at 0.
REQ-031 If reset asserts in the middle of a clear, the block SHALL abort the sweep and return to IDLE with wr_ready=1 on the first edge after rst_n rises.

Configuration
REQ-032 With macro EN_REG_BANK_PARITY_EN defined, each row SHALL store one extra even-parity bit computed from wr_data.
REQ-033 With EN_REG_BANK_PARITY_EN defined, the block SHALL add output rd_perr (1 bit), which is registered alongside rd_data and is 1 when the stored parity mismatches.
REQ-034 With EN_REG_BANK_PARITY_EN defined, a clear SHALL write data 0 with parity 0.
REQ-035 Without EN_REG_BANK_PARITY_EN, the block SHALL have no parity storage and no rd_perr port.

Structure
REQ-036 The shared include en_reg_bank_defs.vh SHALL hold the FSM state encodings (IDLE=1'b0, CLEAR=1'b1) and the default DEPTH and WIDTH.
REQ-037 The block SHALL have one sub-module, en_row_reg, which is one WIDTH-bit register row with asynchronous active-low reset and a load enable; the block instantiates DEPTH copies of it, each driven by its bit of row_en.

Verification
REQ-038 Reset, then write 0xA5 to row 3 and read row 3 -> row_en=8'b0000_1000 during the write; rd_data=0xA5 and rd_valid=1 one cycle after rd_en.
REQ-039 Write 0x11 and then 0x22 to row 5 while also reading row 5 in the second cycle -> the read returns 0x11.
REQ-040 Fill all rows with 0xFF and pulse clr_req -> busy=1 for exactly 8 cycles, row_en walks 0x01 to 0x80, and every row then reads 0x00.
REQ-041 During a clear, hold wr_valid=1 -> wr_ready=0 for all 8 cycles, no data write occurs, and the write is accepted on the first IDLE cycle.
REQ-042 Assert rst_n=0 on sweep cycle 4 -> all rows read 0, busy=0, and wr_ready=1 after release.
REQ-043 With EN_REG_BANK_PARITY_EN defined, force the stored parity bit of row 2 to flip and read row 2 -> rd_perr=1; a normal read gives rd_perr=0.

Source files
------------

// File: rtl/en_reg_bank_pkg.sv
// en_reg_bank package: state constants and defaults from the shared defs.
// Optional parity storage is enabled by EN_REG_BANK_PARITY_EN.
`include "en_reg_bank_defs.vh"

package en_reg_bank_pkg;

  localparam logic ST_IDLE  = `ERB_ST_IDLE;
  localparam logic ST_CLEAR = `ERB_ST_CLEAR;

  localparam int ERB_DEF_DEPTH = `ERB_DEPTH;
  localparam int ERB_DEF_WIDTH = `ERB_WIDTH;

endpackage

// File: rtl/en_reg_bank_defs.vh
// en_reg_bank shared defines: FSM state encodings and default geometry.
`ifndef EN_REG_BANK_DEFS_VH
`define EN_REG_BANK_DEFS_VH
`define ERB_ST_IDLE  1'b0
`define ERB_ST_CLEAR 1'b1
`define ERB_DEPTH    8
`define ERB_WIDTH    8
`endif

// File: rtl/en_row_reg.sv
// en_row_reg: one storage row with async active-low reset and load enable.
// Used DEPTH times by en_reg_bank.
module en_row_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/en_reg_bank.sv
// en_reg_bank: enable-register bank with bulk-clear sweep FSM.
// Define EN_REG_BANK_PARITY_EN to add per-row even parity and rd_perr.
module en_reg_bank
  import en_reg_bank_pkg::*;
#(
  parameter int DEPTH = ERB_DEF_DEPTH,
  parameter int WIDTH = ERB_DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     clr_req,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [DEPTH-1:0]         row_en,
`ifdef EN_REG_BANK_PARITY_EN
  output logic                     rd_perr,
`endif
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

`ifdef EN_REG_BANK_PARITY_EN
  localparam int RW = WIDTH + 1;
`else
  localparam int RW = WIDTH;
`endif

  logic          state;
  logic [AW-1:0] sweep;
  logic          clr_st;
  logic          wr_fire;
  logic [RW-1:0] ld_data;
  logic [RW-1:0] row_q [DEPTH];

  assign clr_st   = (state == ST_CLEAR);
  assign wr_ready = ~clr_st;
  assign busy     = clr_st;
  assign wr_fire  = wr_valid & wr_ready;

`ifdef EN_REG_BANK_PARITY_EN
  assign ld_data = clr_st ? '0 : {^wr_data, wr_data};
`else
  assign ld_data = clr_st ? '0 : wr_data;
`endif

  always_comb begin
    row_en = '0;
    unique case (1'b1)
      clr_st:  row_en[sweep]   = 1'b1;
      wr_fire: row_en[wr_addr] = 1'b1;
      default: ;
    endcase
  end

  // A clr_req coincident with a write is only sampled in IDLE, so the
  // write lands this edge and the sweep starts on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sweep <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state <= ST_CLEAR;
            sweep <= '0;
          end
        end
        ST_CLEAR: begin
          if (sweep == LAST) begin
            state <= ST_IDLE;
            sweep <= '0;
          end else begin
            sweep <= sweep + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          sweep <= '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    en_row_reg #(
      .W(RW)
    ) u_row (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (row_en[i]),
      .d    (ld_data),
      .q    (row_q[i])
    );
  end

  // Read samples row outputs before this edge's load: read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= row_q[rd_addr][WIDTH-1:0];
      end
    end
  end

`ifdef EN_REG_BANK_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_perr <= 1'b0;
    end else if (rd_en) begin
      rd_perr <= ^row_q[rd_addr];
    end
  end
`endif

endmodule

// File: tb/tb_en_reg_bank.sv
// tb_en_reg_bank: directed scoreboard bench for en_reg_bank.
// Reads are queued when issued and compared when rd_valid is due.
module tb_en_reg_bank;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int AW = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_valid;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             clr_req;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [DEPTH-1:0] row_en;
  logic             busy;
`ifdef EN_REG_BANK_PARITY_EN
  logic             rd_perr;
`endif

  en_reg_bank #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .clr_req (clr_req),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .row_en  (row_en),
`ifdef EN_REG_BANK_PARITY_EN
    .rd_perr (rd_perr),
`endif
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] m_mem [DEPTH];
  logic             m_busy;
  logic [AW-1:0]    m_cnt;
  logic [WIDTH-1:0] last_rd;
  logic [WIDTH-1:0] rdq [$];
  int               busy_cycles;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_busy  = 1'b0;
    m_cnt   = '0;
    last_rd = '0;
    rdq.delete();
  endtask

  // One clock: check combinational outputs, advance model, check read.
  task automatic cycle();
    logic             acc;
    logic             pend;
    logic [DEPTH-1:0] exp_en;
    logic [WIDTH-1:0] e;
    #1;
    acc    = wr_valid && !m_busy;
    exp_en = '0;
    if (m_busy) exp_en[m_cnt] = 1'b1;
    else if (acc) exp_en[wr_addr] = 1'b1;
    chk("row_en", 32'(row_en), 32'(exp_en));
    chk("wr_ready", 32'(wr_ready), 32'(!m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    if (busy === 1'b1) busy_cycles++;
    pend = rd_en;
    if (rd_en) rdq.push_back(m_mem[rd_addr]);
    if (acc) m_mem[wr_addr] = wr_data;
    if (m_busy) begin
      m_mem[m_cnt] = '0;
      if (m_cnt == AW'(DEPTH - 1)) begin
        m_busy = 1'b0;
        m_cnt  = '0;
      end else begin
        m_cnt = m_cnt + 1'b1;
      end
    end else if (clr_req) begin
      m_busy = 1'b1;
      m_cnt  = '0;
    end
    @(posedge clk);
    #1;
    if (pend) begin
      e = rdq.pop_front();
      chk("rd_valid", 32'(rd_valid), 32'd1);
      chk("rd_data", 32'(rd_data), 32'(e));
      last_rd = e;
    end else begin
      chk("rd_valid_idle", 32'(rd_valid), 32'd0);
      chk("rd_data_hold", 32'(rd_data), 32'(last_rd));
    end
  endtask

  task automatic idle_in();
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    rd_en    = 1'b0;
  endtask

  task automatic wr(input int a, input logic [WIDTH-1:0] d);
    idle_in();
    wr_valid = 1'b1;
    wr_addr  = AW'(a);
    wr_data  = d;
    cycle();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input int a);
    idle_in();
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    cycle();
    rd_en = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) rd(i);
    cycle();
  endtask

  task automatic pulse_clr();
    idle_in();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    model_reset();
    #12;
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_row_en", 32'(row_en), 32'd0);
    rst_n = 1'b1;
    cycle();

    // Basic write and read of row 3
    idle_in();
    wr_valid = 1'b1;
    wr_addr  = 3'd3;
    wr_data  = 8'hA5;
    #1;
    chk("wr_row_en_3", 32'(row_en), 32'h08);
    cycle();
    rd(3);
    chk("rd_row3", 32'(rd_data), 32'hA5);
    cycle();

    // Read-before-write on row 5
    wr(5, 8'h11);
    wr_valid = 1'b1;
    wr_addr  = 3'd5;
    wr_data  = 8'h22;
    rd_en    = 1'b1;
    rd_addr  = 3'd5;
    cycle();
    chk("rbw_old", 32'(rd_data), 32'h11);
    rd(5);
    chk("rbw_new", 32'(rd_data), 32'h22);

    // Fill with FF, clear; reads and a stray clr_req during the sweep
    for (int i = 0; i < DEPTH; i++) wr(i, 8'hFF);
    pulse_clr();
    busy_cycles = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      idle_in();
      clr_req = (i == 3);
      rd_en   = 1'b1;
      rd_addr = AW'(DEPTH - 1 - i);
      cycle();
    end
    idle_in();
    chk("busy_cycles", 32'(busy_cycles), 32'd8);
    read_all();

    // Held write during clear is accepted on the first IDLE cycle
    for (int i = 0; i < DEPTH; i++) wr(i, 8'(i * 17 + 1));
    pulse_clr();
    busy_cycles = 0;
    wr_valid = 1'b1;
    wr_addr  = 3'd6;
    wr_data  = 8'h5A;
    for (int i = 0; i < DEPTH + 1; i++) cycle();
    wr_valid = 1'b0;
    chk("held_busy_cycles", 32'(busy_cycles), 32'd8);
    read_all();
    chk("held_row6_last", 32'(rd_data), 32'h00);
    rd(6);
    chk("held_row6", 32'(rd_data), 32'h5A);

    // Write and clr_req together: write lands, then sweep clears it
    idle_in();
    wr_valid = 1'b1;
    wr_addr  = 3'd1;
    wr_data  = 8'h3C;
    clr_req  = 1'b1;
    cycle();
    idle_in();
    rd_en   = 1'b1;
    rd_addr = 3'd1;
    cycle();
    chk("wr_then_clr", 32'(rd_data), 32'h3C);
    idle_in();
    for (int i = 0; i < DEPTH; i++) cycle();
    read_all();

    // Reset in the middle of a sweep
    for (int i = 0; i < DEPTH; i++) wr(i, 8'hC3);
    pulse_clr();
    for (int i = 0; i < 4; i++) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(wr_ready), 32'd1);
    chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    read_all();

`ifdef EN_REG_BANK_PARITY_EN
    wr(2, 8'h07);
    rd(2);
    chk("perr_clean", 32'(rd_perr), 32'd0);
    force dut.g_row[2].u_row.q[WIDTH] = 1'b0;
    rd(2);
    chk("perr_flip", 32'(rd_perr), 32'd1);
    release dut.g_row[2].u_row.q[WIDTH];
    wr(2, 8'h07);
    rd(2);
    chk("perr_rewrite", 32'(rd_perr), 32'd0);
`endif

    chk("scoreboard_empty", 32'(rdq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
